// File: rtl/mem_io_bridge_pkg.sv
// rtl/mem_io_bridge_pkg.sv - shared memory-command, address-map and bridge-state definitions
package cpu_defs;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [1:0] MCMD_ILLEGAL = 2'b11;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } bridge_state_e;

endpackage

// File: rtl/mem_io_bridge_ram_sync.sv
// rtl/mem_io_bridge_ram_sync.sv - single-port RAM with synchronous read and write, no reset
module ram_sync #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The read register only moves on read cycles so it can hold the last load.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU memory bridge: decodes accesses to RAM, LED register and switch port
module mem_io_bridge
    import cpu_defs::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RAM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        bus_err,
    output logic [15:0] access_count
);

    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    bridge_state_e state_q;
    logic [3:0]    cnt_q;
    logic [8:0]    addr_q;
    logic          wr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   io_rdata_q;
    logic          rd_sel_ram_q;
    logic          mem_ready_q;
    logic [7:0]    led_q;
    logic          bus_err_q;
    logic [15:0]   count_q;
    logic [7:0]    sw_meta_q;
    logic [7:0]    sw_sync_q;

    logic          start;
    logic          enter_done;
    logic [8:0]    acc_addr;
    logic          acc_wr;
    logic [15:0]   acc_wdata;
    logic          hit_ram;
    logic          hit_led;
    logic          hit_sw;
    logic          ram_en;
    logic [15:0]   ram_rdata;

    // With zero wait states the access completes straight from IDLE, so decode
    // must look at the live inputs there and at the latched copies otherwise.
    always_comb begin
        start      = (state_q == IDLE) && ((mem_cmd == MREAD) || (mem_cmd == MWRITE));
        enter_done = (start && (WAIT_CYCLES == 0)) || ((state_q == BUSY) && (cnt_q == 4'd0));
        acc_addr   = (state_q == IDLE) ? mem_addr : addr_q;
        acc_wr     = (state_q == IDLE) ? (mem_cmd == MWRITE) : wr_q;
        acc_wdata  = (state_q == IDLE) ? write_data : wdata_q;
        hit_ram    = (32'(acc_addr) < RAM_WORDS);
        hit_led    = (acc_addr == LED_ADDR);
        hit_sw     = (acc_addr == SW_ADDR);
        ram_en     = enter_done && hit_ram && reset;
    end

    ram_sync #(
        .DEPTH (RAM_WORDS),
        .WIDTH (16)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (acc_wr),
        .addr_i  (acc_addr[RAM_AW-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 9'd0;
            wr_q         <= 1'b0;
            wdata_q      <= 16'd0;
            io_rdata_q   <= 16'd0;
            rd_sel_ram_q <= 1'b0;
            mem_ready_q  <= 1'b0;
            led_q        <= 8'd0;
            bus_err_q    <= 1'b0;
            count_q      <= 16'd0;
            sw_meta_q    <= 8'd0;
            sw_sync_q    <= 8'd0;
        end else begin
            sw_meta_q   <= sw;
            sw_sync_q   <= sw_meta_q;
            mem_ready_q <= enter_done;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= mem_addr;
                        wr_q    <= (mem_cmd == MWRITE);
                        wdata_q <= write_data;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= WAIT_INIT;
                        end
                    end else if (mem_cmd == MCMD_ILLEGAL) begin
                        bus_err_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (enter_done) begin
                if (acc_wr) begin
                    if (hit_led) begin
                        led_q <= acc_wdata[7:0];
                    end else if (!hit_ram) begin
                        bus_err_q <= 1'b1;
                    end
                end else if (hit_ram) begin
                    rd_sel_ram_q <= 1'b1;
                end else begin
                    rd_sel_ram_q <= 1'b0;
                    if (hit_led) begin
                        io_rdata_q <= {8'h00, led_q};
                    end else if (hit_sw) begin
                        io_rdata_q <= {8'h00, sw_sync_q};
                    end else begin
                        io_rdata_q <= 16'h0000;
                        bus_err_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign read_data    = rd_sel_ram_q ? ram_rdata : io_rdata_q;
    assign mem_ready    = mem_ready_q;
    assign led          = led_q;
    assign bus_err      = bus_err_q;
    assign access_count = count_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - bench for mem_io_bridge with wait-state variants 0..3 side by side
module tb_mem_io_bridge;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic [1:0]  cmd  [4];
    logic [8:0]  addr [4];
    logic [15:0] wd   [4];
    logic [15:0] rd   [4];
    logic        rdy  [4];
    logic [7:0]  led  [4];
    logic        err  [4];
    logic [15:0] cnt  [4];

    logic [15:0] m_ram [4][256];
    logic [15:0] m_rd  [4];
    logic [7:0]  m_led [4];
    logic        m_err [4];
    logic [15:0] m_cnt [4];
    logic [7:0]  m_sw;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gi
            mem_io_bridge #(
                .WAIT_CYCLES (g),
                .RAM_WORDS   (256)
            ) dut (
                .clk          (clk),
                .reset        (reset),
                .mem_cmd      (cmd[g]),
                .mem_addr     (addr[g]),
                .write_data   (wd[g]),
                .read_data    (rd[g]),
                .mem_ready    (rdy[g]),
                .sw           (sw),
                .led          (led[g]),
                .bus_err      (err[g]),
                .access_count (cnt[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input int k, input string tag);
        chk({tag, ".read_data"},    32'(rd[k]),  32'(m_rd[k]));
        chk({tag, ".led"},          32'(led[k]), 32'(m_led[k]));
        chk({tag, ".bus_err"},      32'(err[k]), 32'(m_err[k]));
        chk({tag, ".access_count"}, 32'(cnt[k]), 32'(m_cnt[k]));
    endtask

    // One full CPU access; the reference effect is worked out from the address map.
    task automatic do_access(input int k, input logic [1:0] c, input logic [8:0] a,
                             input logic [15:0] d, input bit scramble, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        cmd[k] = c; addr[k] = a; wd[k] = d;
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (rdy[k]) seen = 1'b1;
            else if (scramble) begin
                addr[k] = 9'(a + 9'd1);
                wd[k]   = 16'($urandom);
            end
        end
        chk({tag, ".ready_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(n), 32'(k + 1));
        cmd[k] = MNONE;
        if (a < 9'h100) begin
            if (c == MWRITE) m_ram[k][a[7:0]] = d;
            else m_rd[k] = m_ram[k][a[7:0]];
        end else if (a == 9'h100) begin
            if (c == MWRITE) m_led[k] = d[7:0];
            else m_rd[k] = {8'h00, m_led[k]};
        end else if (a == 9'h140) begin
            if (c == MWRITE) m_err[k] = 1'b1;
            else m_rd[k] = {8'h00, m_sw};
        end else begin
            m_err[k] = 1'b1;
            if (c == MREAD) m_rd[k] = 16'h0000;
        end
        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
        @(negedge clk);
        chk({tag, ".ready_pulse"}, 32'(rdy[k]), 32'd0);
        chk_state(k, tag);
    endtask

    task automatic do_illegal(input int k);
        @(negedge clk);
        cmd[k] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("illegal.no_ready", 32'(rdy[k]), 32'd0);
        end
        cmd[k] = MNONE;
        m_err[k] = 1'b1;
        chk("illegal.bus_err", 32'(err[k]), 32'd1);
    endtask

    task automatic set_sw(input logic [7:0] v);
        @(negedge clk);
        sw = v;
        m_sw = v;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [8:0]  ra;
        logic [1:0]  rc;
        int          sel;
        bit          rdy_seen;

        reset = 1'b0;
        sw    = 8'h00;
        m_sw  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            cmd[k] = MNONE; addr[k] = 9'd0; wd[k] = 16'd0;
            m_rd[k] = 16'd0; m_led[k] = 8'd0; m_err[k] = 1'b0; m_cnt[k] = 16'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset.mem_ready", 32'(rdy[k]), 32'd0);
            chk_state(k, "reset");
        end
        reset = 1'b1;

        do_access(1, MWRITE, 9'h005, 16'hBEEF, 1'b0, "w1_wr005");
        do_access(1, MREAD,  9'h005, 16'h0000, 1'b0, "w1_rd005");
        chk("w1.read_beef", 32'(rd[1]), 32'h0000BEEF);
        chk("w1.count2", 32'(cnt[1]), 32'd2);

        do_access(0, MWRITE, 9'h100, 16'h12A5, 1'b0, "w0_wrled");
        chk("w0.led_a5", 32'(led[0]), 32'hA5);
        do_access(0, MREAD,  9'h100, 16'h0000, 1'b0, "w0_rdled");
        chk("w0.rd_00a5", 32'(rd[0]), 32'h00A5);

        set_sw(8'h3C);
        do_access(0, MREAD,  9'h140, 16'h0000, 1'b0, "w0_rdsw");
        chk("w0.rd_003c", 32'(rd[0]), 32'h003C);
        do_access(0, MWRITE, 9'h140, 16'hFFFF, 1'b0, "w0_wrsw");
        chk("w0.wrsw_led", 32'(led[0]), 32'hA5);

        do_access(1, MREAD, 9'h1FF, 16'h0000, 1'b0, "w1_rd1ff");
        chk("w1.rd1ff_zero", 32'(rd[1]), 32'd0);
        do_illegal(2);

        do_access(3, MWRITE, 9'h011, 16'h7777, 1'b0, "w3_wr011");
        do_access(3, MWRITE, 9'h010, 16'h1111, 1'b1, "w3_wr010_scr");
        do_access(3, MREAD,  9'h010, 16'h0000, 1'b0, "w3_rd010");
        chk("w3.rd_1111", 32'(rd[3]), 32'h1111);
        do_access(3, MREAD,  9'h011, 16'h0000, 1'b0, "w3_rd011");
        chk("w3.rd_7777", 32'(rd[3]), 32'h7777);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 17; i++) begin
                ra = (i == 16) ? 9'h0FF : 9'(i);
                do_access(k, MWRITE, ra, 16'($urandom), 1'b0, "init");
            end
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0) set_sw(8'($urandom));
                sel = $urandom_range(0, 9);
                rc  = $urandom_range(0, 1) ? MWRITE : MREAD;
                case (sel)
                    5, 6:    ra = 9'h100;
                    7:       ra = 9'h140;
                    8:       ra = 9'h180 | 9'($urandom_range(0, 127));
                    default: begin
                        sel = $urandom_range(0, 16);
                        ra  = (sel == 16) ? 9'h0FF : 9'(sel);
                    end
                endcase
                if (sel == 9) do_illegal(k);
                else do_access(k, rc, ra, 16'($urandom), 1'b0, "rand");
            end
        end

        do_access(2, MWRITE, 9'h020, 16'hAAAA, 1'b0, "w2_wr020");
        do_access(2, MWRITE, 9'h100, 16'h00C3, 1'b0, "w2_wrled");
        @(negedge clk);
        cmd[2] = MWRITE; addr[2] = 9'h020; wd[2] = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[2]) rdy_seen = 1'b1;
            cmd[2] = MNONE;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[2]) rdy_seen = 1'b1;
        end
        chk("rst_abort.no_ready", 32'(rdy_seen), 32'd0);
        for (int k = 0; k < 4; k++) begin
            m_rd[k] = 16'd0; m_led[k] = 8'd0; m_err[k] = 1'b0; m_cnt[k] = 16'd0;
        end
        chk_state(2, "rst_abort");
        do_access(2, MREAD, 9'h020, 16'h0000, 1'b0, "w2_rd020");
        chk("w2.rd_aaaa", 32'(rd[2]), 32'hAAAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
